// File: rtl/timer_display_mux.sv
// Four-digit multiplexed common-anode 7-segment driver for an mm:ss countdown.
// Digits are snapshotted once per scan frame; outputs are registered and gated by a blink phase.
module timer_display_mux #(
   parameter int REFRESH_DIV   = 50000,
   parameter int BLINK_DIV     = 25000000,
   parameter bit BLANK_LEADING = 1'b1
) (
   input  logic       Clk,
   input  logic       reset,
   input  logic [7:0] Countmin,
   input  logic [7:0] Countsec,
   input  logic       blink_led,
   output logic [6:0] seg,
   output logic [3:0] an,
   output logic       dp
);

   localparam int RW = $clog2(REFRESH_DIV);
   localparam int BW = $clog2(BLINK_DIV);
   localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
   localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);
   localparam logic [6:0]    SEG_BLANK    = 7'h7F;
   localparam logic [6:0]    SEG_DASH     = 7'h3F;

   typedef enum logic {
      PHASE_OFF = 1'b0,
      PHASE_ON  = 1'b1
   } blink_phase_t;

   logic [RW-1:0] refresh_q, refresh_d;
   logic [1:0]    index_q, index_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   blink_phase_t  phase_q, phase_d;
   logic [15:0]   snap_q, snap_d;
   logic          blink_prev_q, blink_prev_d;
   logic          started_q, started_d;
   logic [6:0]    seg_q, seg_d;
   logic [3:0]    an_q, an_d;
   logic          dp_q, dp_d;
   logic          tick;
   logic [6:0]    digit_seg [4];

   function automatic logic [6:0] decode_bcd(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = SEG_DASH;
      endcase
      return s;
   endfunction

   assign tick = (refresh_q == REFRESH_LAST);

   // Refresh scan, frame snapshot and blink phase next-state.
   always_comb begin
      refresh_d    = refresh_q;
      index_d      = index_q;
      snap_d       = snap_q;
      started_d    = started_q;
      blink_cnt_d  = blink_cnt_q;
      phase_d      = phase_q;
      blink_prev_d = blink_led;

      if (tick) begin
         refresh_d = '0;
         index_d   = index_q + 2'd1;
         started_d = 1'b1;
         if (index_q == 2'd3) begin
            snap_d = {Countmin, Countsec};
         end
      end else begin
         refresh_d = refresh_q + 1'b1;
      end

      if (!blink_led || !blink_prev_q) begin
         // Idle or freshly raised flag: restart the blink with the display lit.
         blink_cnt_d = '0;
         phase_d     = PHASE_ON;
      end else if (blink_cnt_q == BLINK_LAST) begin
         blink_cnt_d = '0;
         phase_d     = (phase_q == PHASE_ON) ? PHASE_OFF : PHASE_ON;
      end else begin
         blink_cnt_d = blink_cnt_q + 1'b1;
      end
   end

   // Decode from the next snapshot so digit 0 of a new frame sees the value captured on this edge.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_decode
         logic [3:0] nibble;
         assign nibble = snap_d[gi*4 +: 4];
         if (gi == 3) begin : g_lead
            assign digit_seg[gi] = (BLANK_LEADING && (nibble == 4'h0)) ? SEG_BLANK
                                                                        : decode_bcd(nibble);
         end else begin : g_plain
            assign digit_seg[gi] = decode_bcd(nibble);
         end
      end
   endgenerate

   always_comb begin
      seg_d = SEG_BLANK;
      an_d  = 4'hF;
      dp_d  = 1'b1;
      if (started_d && (phase_d == PHASE_ON)) begin
         seg_d = digit_seg[index_d];
         an_d  = ~(4'b0001 << index_d);
         dp_d  = (index_d != 2'd2);
      end
   end

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         refresh_q    <= '0;
         index_q      <= 2'd3;
         blink_cnt_q  <= '0;
         phase_q      <= PHASE_ON;
         snap_q       <= 16'h0000;
         blink_prev_q <= 1'b0;
         started_q    <= 1'b0;
         seg_q        <= SEG_BLANK;
         an_q         <= 4'hF;
         dp_q         <= 1'b1;
      end else begin
         refresh_q    <= refresh_d;
         index_q      <= index_d;
         blink_cnt_q  <= blink_cnt_d;
         phase_q      <= phase_d;
         snap_q       <= snap_d;
         blink_prev_q <= blink_prev_d;
         started_q    <= started_d;
         seg_q        <= seg_d;
         an_q         <= an_d;
         dp_q         <= dp_d;
      end
   end

   assign seg = seg_q;
   assign an  = an_q;
   assign dp  = dp_q;

endmodule

// File: tb/tb_timer_display_mux.sv
// Bench for timer_display_mux: two instances (leading blank on/off) checked every cycle
// against an arithmetic model built from elapsed-cycle counts.
module tb_timer_display_mux;
   localparam int R = 4;
   localparam int B = 16;

   logic       Clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] Countmin = 8'h00;
   logic [7:0] Countsec = 8'h00;
   logic       blink_led = 1'b0;
   logic [6:0] seg_a, seg_b;
   logic [3:0] an_a, an_b;
   logic       dp_a, dp_b;

   timer_display_mux #(.REFRESH_DIV(R), .BLINK_DIV(B), .BLANK_LEADING(1'b1)) dut_a (
      .Clk(Clk), .reset(reset), .Countmin(Countmin), .Countsec(Countsec),
      .blink_led(blink_led), .seg(seg_a), .an(an_a), .dp(dp_a));

   timer_display_mux #(.REFRESH_DIV(R), .BLINK_DIV(B), .BLANK_LEADING(1'b0)) dut_b (
      .Clk(Clk), .reset(reset), .Countmin(Countmin), .Countsec(Countsec),
      .blink_led(blink_led), .seg(seg_b), .an(an_b), .dp(dp_b));

   always #5 Clk = ~Clk;

   int checks = 0;
   int errors = 0;

   // Model: edges since reset release, snapshot, blink rise edge, previous blink level.
   int          m_n;
   int          m_rise;
   logic        m_prev;
   logic        m_phase;
   logic [15:0] m_snap;
   logic [11:0] exp_a, exp_b;

   function automatic logic [6:0] seg_of(input logic [3:0] v);
      case (v)
         4'd0: return 7'h40;
         4'd1: return 7'h79;
         4'd2: return 7'h24;
         4'd3: return 7'h30;
         4'd4: return 7'h19;
         4'd5: return 7'h12;
         4'd6: return 7'h02;
         4'd7: return 7'h78;
         4'd8: return 7'h00;
         4'd9: return 7'h10;
         default: return 7'h3F;
      endcase
   endfunction

   task automatic predict();
      int k, idx;
      logic [3:0] nib, an_e;
      logic [6:0] sg;
      k = m_n / R;
      if (k == 0 || !m_phase) begin
         exp_a = {4'hF, 7'h7F, 1'b1};
         exp_b = exp_a;
      end else begin
         idx  = (k - 1) % 4;
         nib  = m_snap[idx*4 +: 4];
         sg   = seg_of(nib);
         an_e = ~(4'b0001 << idx);
         exp_b = {an_e, sg, (idx != 2)};
         exp_a = {an_e, (idx == 3 && nib == 4'h0) ? 7'h7F : sg, (idx != 2)};
      end
   endtask

   task automatic model_reset();
      m_n = 0; m_rise = 0; m_prev = 1'b0; m_phase = 1'b1; m_snap = 16'h0000;
      predict();
   endtask

   task automatic model_edge();
      m_n++;
      if (m_n % R == 0 && ((m_n / R - 1) % 4 == 0)) m_snap = {Countmin, Countsec};
      if (!blink_led) begin
         m_phase = 1'b1;
      end else begin
         if (!m_prev) m_rise = m_n;
         m_phase = (((m_n - m_rise) / B) % 2 == 0);
      end
      m_prev = blink_led;
      predict();
   endtask

   task automatic step();
      @(posedge Clk);
      if (reset) model_reset(); else model_edge();
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; Countmin = 8'h12; Countsec = 8'h34; blink_led = 1'b0;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if ({an_a, seg_a, dp_a} !== exp_a) begin
            errors++;
            $display("FAIL reset_hold: got an=%h seg=%h dp=%b expected an=%h seg=%h dp=%b",
                     an_a, seg_a, dp_a, exp_a[11:8], exp_a[7:1], exp_a[0]);
         end
      end
      reset = 1'b0;
      for (int i = 1; i <= 4*R + 2; i++) begin
         step();
         checks++;
         if ({an_a, seg_a, dp_a} !== exp_a) begin
            errors++;
            $display("FAIL first_frame_a: got an=%h seg=%h dp=%b expected an=%h seg=%h dp=%b",
                     an_a, seg_a, dp_a, exp_a[11:8], exp_a[7:1], exp_a[0]);
         end
         checks++;
         if ({an_b, seg_b, dp_b} !== exp_b) begin
            errors++;
            $display("FAIL first_frame_b: got an=%h seg=%h dp=%b expected an=%h seg=%h dp=%b",
                     an_b, seg_b, dp_b, exp_b[11:8], exp_b[7:1], exp_b[0]);
         end
         if (i == R) begin
            checks++;
            if (an_a !== 4'hE || seg_a !== 7'h19 || dp_a !== 1'b1) begin
               errors++;
               $display("FAIL first_digit: got an=%h seg=%h dp=%b expected an=e seg=19 dp=1",
                        an_a, seg_a, dp_a);
            end
         end
      end
      $display("test_reset done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_frame_coherence();
      bit found = 0;
      for (int i = 0; i < 8*R && !found; i++) begin
         step();
         if (m_n % R == 0 && ((m_n / R - 1) % 4 == 0)) found = 1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL frame_sync: got no digit-0 tick within %0d cycles, required one", 8*R);
      end
      Countsec = 8'h33;
      for (int i = 1; i <= 4*R; i++) begin
         step();
         checks++;
         if ({an_a, seg_a, dp_a} !== exp_a) begin
            errors++;
            $display("FAIL coherence: got an=%h seg=%h dp=%b expected an=%h seg=%h dp=%b",
                     an_a, seg_a, dp_a, exp_a[11:8], exp_a[7:1], exp_a[0]);
         end
         if (i == 4*R) begin
            checks++;
            if (an_a !== 4'hE || seg_a !== 7'h30) begin
               errors++;
               $display("FAIL next_frame_digit0: got an=%h seg=%h expected an=e seg=30", an_a, seg_a);
            end
         end
      end
      $display("test_frame_coherence done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_leading_blank();
      Countmin = 8'h05; Countsec = 8'h0A;
      for (int i = 0; i < 12*R; i++) begin
         step();
         checks++;
         if ({an_a, seg_a, dp_a} !== exp_a) begin
            errors++;
            $display("FAIL blank_on: got an=%h seg=%h dp=%b expected an=%h seg=%h dp=%b",
                     an_a, seg_a, dp_a, exp_a[11:8], exp_a[7:1], exp_a[0]);
         end
         checks++;
         if ({an_b, seg_b, dp_b} !== exp_b) begin
            errors++;
            $display("FAIL blank_off: got an=%h seg=%h dp=%b expected an=%h seg=%h dp=%b",
                     an_b, seg_b, dp_b, exp_b[11:8], exp_b[7:1], exp_b[0]);
         end
      end
      $display("test_leading_blank done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_blink();
      bit off_seen = 0;
      Countmin = 8'h59; Countsec = 8'h07;
      blink_led = 1'b1;
      for (int i = 0; i < 5*B; i++) begin
         step();
         checks++;
         if ({an_a, seg_a, dp_a} !== exp_a) begin
            errors++;
            $display("FAIL blink_run: got an=%h seg=%h dp=%b expected an=%h seg=%h dp=%b",
                     an_a, seg_a, dp_a, exp_a[11:8], exp_a[7:1], exp_a[0]);
         end
      end
      for (int i = 0; i < 2*B && !off_seen; i++) begin
         step();
         if (!m_phase) off_seen = 1;
      end
      checks++;
      if (!off_seen || an_a !== 4'hF) begin
         errors++;
         $display("FAIL blink_off_phase: got an=%h seen=%0d expected an=f with phase off", an_a, off_seen);
      end
      blink_led = 1'b0;
      for (int i = 0; i < 2*R + 1; i++) begin
         step();
         checks++;
         if ({an_a, seg_a, dp_a} !== exp_a) begin
            errors++;
            $display("FAIL blink_drop: got an=%h seg=%h dp=%b expected an=%h seg=%h dp=%b",
                     an_a, seg_a, dp_a, exp_a[11:8], exp_a[7:1], exp_a[0]);
         end
      end
      $display("test_blink done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_coincide();
      blink_led = 1'b0;
      for (int i = 0; i < R + 1 && (m_n % R != R - 1); i++) step();
      blink_led = 1'b1;
      for (int i = 0; i < 3*B + 2; i++) begin
         step();
         checks++;
         if ({an_a, seg_a, dp_a} !== exp_a) begin
            errors++;
            $display("FAIL coincide: got an=%h seg=%h dp=%b expected an=%h seg=%h dp=%b",
                     an_a, seg_a, dp_a, exp_a[11:8], exp_a[7:1], exp_a[0]);
         end
         checks++;
         if ($countones(~an_a) > 1) begin
            errors++;
            $display("FAIL onehot_coincide: got an=%h expected at most one low bit", an_a);
         end
      end
      blink_led = 1'b0;
      $display("test_coincide done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_random();
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(7, 0) == 0) Countmin = 8'($urandom);
         if ($urandom_range(3, 0) == 0) Countsec = 8'($urandom);
         if ($urandom_range(29, 0) == 0) blink_led = ~blink_led;
         step();
         checks++;
         if ({an_a, seg_a, dp_a} !== exp_a || {an_b, seg_b, dp_b} !== exp_b) begin
            errors++;
            $display("FAIL random: got a=%h/%h/%b b=%h/%h/%b expected a=%h/%h/%b b=%h/%h/%b",
                     an_a, seg_a, dp_a, an_b, seg_b, dp_b,
                     exp_a[11:8], exp_a[7:1], exp_a[0], exp_b[11:8], exp_b[7:1], exp_b[0]);
         end
         checks++;
         if ($countones(~an_a) > 1 || $countones(~an_b) > 1) begin
            errors++;
            $display("FAIL onehot_random: got an_a=%h an_b=%h expected at most one low bit", an_a, an_b);
         end
      end
      $display("test_random done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_reset_mid();
      bit hit = 0;
      Countmin = 8'h12; Countsec = 8'h34; blink_led = 1'b1;
      for (int i = 0; i < 200 && !hit; i++) begin
         step();
         if (an_a == 4'hB) hit = 1;
      end
      checks++;
      if (!hit) begin
         errors++;
         $display("FAIL mid_sync: got no an=b within 200 cycles, required one");
      end
      #2 reset = 1'b1;
      model_reset();
      #1;
      checks++;
      if (an_a !== 4'hF || seg_a !== 7'h7F || dp_a !== 1'b1 || an_b !== 4'hF) begin
         errors++;
         $display("FAIL async_reset: got an=%h seg=%h dp=%b expected an=f seg=7f dp=1",
                  an_a, seg_a, dp_a);
      end
      step();
      step();
      reset = 1'b0;
      for (int i = 1; i <= 4*R + 2; i++) begin
         step();
         checks++;
         if ({an_a, seg_a, dp_a} !== exp_a) begin
            errors++;
            $display("FAIL restart: got an=%h seg=%h dp=%b expected an=%h seg=%h dp=%b",
                     an_a, seg_a, dp_a, exp_a[11:8], exp_a[7:1], exp_a[0]);
         end
         if (i == R) begin
            checks++;
            if (an_a !== 4'hE || seg_a !== 7'h19) begin
               errors++;
               $display("FAIL restart_digit: got an=%h seg=%h expected an=e seg=19", an_a, seg_a);
            end
         end
      end
      blink_led = 1'b0;
      $display("test_reset_mid done: checks=%0d errors=%0d", checks, errors);
   endtask

   initial begin
      model_reset();
      test_reset();
      test_frame_coherence();
      test_leading_blank();
      test_blink();
      test_coincide();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/timer_display_mux.md
Name: timer_display_mux

Overview:
- Downstream display stage for the mm:ss countdown timer.
- Consumes packed-BCD minute/second counts (upper nibble = tens, lower nibble = units) and the end-of-count blink flag.
- Drives a 4-digit, time-multiplexed, common-anode 7-segment display with a minute/second separator dot.
- Captures all digits once per scan frame so a frame never mixes two count values.

Parameters:
- REFRESH_DIV, 50000: clock cycles each digit stays enabled; legal range ≥2.
- BLINK_DIV, 25000000: clock cycles per blink half-period; legal range ≥2.
- BLANK_LEADING, 1: when 1, minute-tens digit is blanked if its nibble is 0.

Ports:
- Clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- Countmin  in  8  packed BCD minutes from the timer.
- Countsec  in  8  packed BCD seconds from the timer.
- blink_led  in  1  timer end-of-count flag; level-sensitive.
- seg  out  7  segment drive, active-low, bit0=a … bit6=g.
- an  out  4  digit enables, active-low; an[0]=sec units, an[1]=sec tens, an[2]=min units, an[3]=min tens.
- dp  out  1  decimal point, active-low.

Behaviour:
- Reset (async assert, any cycle including mid-scan):
  - Outputs: seg=7'h7F, an=4'hF, dp=1.
  - State: refresh counter=0, digit index=3, blink counter=0, blink phase=on, snapshot=16'h0000, blink_led history=0.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1 and wraps to 0.
  - Terminal count (value REFRESH_DIV-1) produces a one-cycle tick.
- On tick:
  - Index advances 0→1→2→3→0.
  - seg, an and dp are registered for the new index in the same clock edge, so all outputs change together with 1-cycle latency from the tick.
  - First enable after reset: index 0, REFRESH_DIV cycles after reset deasserts.
- Snapshot:
  - On the tick where the index wraps 3→0, {Countmin,Countsec} is captured into the snapshot.
  - Digit 0 for that frame uses the just-captured value (bypass), not the previous snapshot.
  - Input changes at any other time do not affect the frame in progress.
- Decode, active-low gfedcba:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - Any nibble >9 displays dash (3F).
  - Blank displays 7F.
- Leading blank: if BLANK_LEADING=1 and snapshot min-tens nibble=0, digit 3 shows 7F while its an bit is still asserted.
- dp: 0 only while index=2 is enabled (separator between minutes and seconds); otherwise 1.
- Blink:
  - While blink_led=0: blink counter held at 0 and phase held on.
  - Rising edge of blink_led (current=1, previous=0): counter cleared, phase set on.
  - While blink_led=1: counter counts 0..BLINK_DIV-1; at terminal count the phase toggles.
  - While phase=off: an=4'hF and dp=1. seg is don't-care but must be 7F. The scan index keeps advancing.
  - Falling edge of blink_led: phase forced on at the next edge.
- Simultaneous events:
  - A tick and a blink toggle in the same cycle are both applied; the blink gate takes priority on an.
  - Reset overrides everything.
- Exactly one an bit is low whenever phase=on and at least one tick has occurred since reset; never more than one.

Test Plan:
- Reset/first digit (REFRESH_DIV=4): reset held 3 cycles, Countmin=8'h12, Countsec=8'h34 → an=F, seg=7F, dp=1 through reset and 3 cycles after; on cycle 4 an=E, seg=19 ("4"); following ticks give an=D/seg=30, an=B/seg=24/dp=0, an=7/seg=79.
- Frame coherence: during a frame, after digit 0 is shown, change Countsec 8'h34→8'h33 → digit 1 still shows "3" from the old snapshot; the next frame's digit 0 shows seg=30.
- Leading blank and invalid BCD: Countmin=8'h05, Countsec=8'h0A → digit 3 seg=7F with an=7; digit 0 seg=3F (dash); digit 1 seg=40. With BLANK_LEADING=0, digit 3 seg=40.
- Blink (BLINK_DIV=16): raise blink_led → displays for 16 cycles, then an=F and dp=1 for 16 cycles, repeating. Drop blink_led while phase=off → next cycle phase on, and scanning resumes at the current index.
- Reset mid-operation: assert reset while an=B and blink_led=1 → an=F and seg=7F immediately (async). After release, the sequence restarts exactly as in scenario 1.
- Tick/blink coincidence: align a blink terminal count with a refresh tick → index advances and an=F in the same cycle; no cycle has two an bits low.
